seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter N, default 5, giving the pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter PATTERN, default 5'b10010, an N-bit pattern whose MSB is the first bit received.
REQ-003 The block SHALL have parameter OVERLAP, default 1, where 1 selects overlapping detection and 0 selects non-overlapping detection.
REQ-004 The block SHALL have parameter CNT_W, default 8, giving the match-counter width.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port en, input, 1 bit: when high, j is sampled as a valid serial bit this cycle.
REQ-008 Port clr, input, 1 bit: synchronous restart of detection and counter.
REQ-009 Port j, input, 1 bit: serial data bit.
REQ-010 Port match, output, 1 bit: Mealy output, combinational, valid in the same cycle as the completing bit.
REQ-011 Port match_q, output, 1 bit: registered (Moore-equivalent) copy of match, one cycle later.
REQ-012 Port count, output, CNT_W bits: number of matches since reset or clr, saturating.

Function
REQ-013 The block SHALL hold a history register hist of N-1 bits and a fill counter fill of ceil(log2(N)) bits, counting valid bits held, saturating at N-1.
REQ-014 match SHALL equal en & ~clr & (fill == N-1) & ({hist, j} == PATTERN), so no match is possible before N valid bits have been received.
REQ-015 On a clock edge with clr low and en high, the block SHALL shift j into the LSB of hist and increment fill, saturating at N-1.
REQ-016 On a clock edge with clr low and en low, hist, fill and count SHALL hold, and match SHALL be 0 in that cycle.
REQ-017 With OVERLAP=1, a match SHALL NOT disturb the shift, so suffix/prefix overlaps are detected (10010010 gives 2 matches).
REQ-018 With OVERLAP=0, the edge completing a match SHALL set fill to 0, so no bit of a matched pattern is reused.
REQ-019 count SHALL increment by 1 on every edge where match is 1, and SHALL hold at 2^CNT_W-1 once reached, with no wrap.
REQ-020 match_q SHALL register match on every edge, independent of en.
REQ-021 clr high on an edge SHALL set hist=0, fill=0, count=0 and match_q=0; clr SHALL take priority over en, and match SHALL be 0 while clr is high.
REQ-022 When a match and clr coincide, clr SHALL win: count becomes 0 and match_q becomes 0 on the next cycle.
REQ-023 j and en SHALL be sampled only at the rising edge; combinational match SHALL follow j between edges.

Reset
REQ-024 rst low SHALL immediately, without waiting for clk, force hist=0, fill=0, count=0 and match_q=0.
REQ-025 While rst is low, match SHALL be 0 regardless of j and en.
REQ-026 On release of rst, detection SHALL restart from an empty history; a reset in mid-pattern SHALL discard all partial progress.

Verification
REQ-027 N=5, PATTERN=10010, OVERLAP=1, en=1, stimulus j=1,0,0,1,0,0,1,0 -> match high on bits 5 and 8, match_q high one cycle after each, count=2.
REQ-028 Same stimulus with OVERLAP=0 -> match high on bit 5 only, count=1.
REQ-029 Stimulus 1,0,0,1,0 with en dropped for 3 cycles between bits 3 and 4, j toggling while en is low -> single match on the 5th enabled bit, count=1.
REQ-030 Stimulus 1,0,0,1 then rst pulsed low asynchronously mid-cycle, then 0 -> no match, count=0, match_q=0 immediately on assertion.
REQ-031 CNT_W=2, continuous 10010 repeated 5 times with OVERLAP=0 -> count=3 after the 3rd match and held at 3 thereafter.
REQ-032 clr asserted on the cycle of a match -> match=0, count=0 and match_q=0 next cycle, and a fresh 10010 afterwards gives count=1.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with Mealy/registered match outputs and a saturating match counter
module seq_detector_param #(
    parameter int N = 5,
    parameter logic [N-1:0] PATTERN = 5'b10010,
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             j,
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] count
);
    localparam int FW = $clog2(N);
    localparam logic [FW-1:0] FULL = FW'(N - 1);
    logic [N-2:0]  hist;
    logic [FW-1:0] fill;
    logic [N-1:0]  win;
    assign win   = {hist, j};
    assign match = rst & en & ~clr & (fill == FULL) & (win == PATTERN);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist    <= '0;
            fill    <= '0;
            count   <= '0;
            match_q <= 1'b0;
        end else if (clr) begin
            hist    <= '0;
            fill    <= '0;
            count   <= '0;
            match_q <= 1'b0;
        end else begin
            match_q <= match;
            if (en) begin
                hist <= win[N-2:0];
                // non-overlapping mode forgets the consumed pattern by emptying the history count
                fill <= (match && !OVERLAP) ? '0 : (fill == FULL) ? fill : fill + 1'b1;
            end
            if (match && count != '1)
                count <= count + 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed checks of overlap, non-overlap and 2-bit-counter variants driven in parallel
module tb_seq_detector_param;
    logic clk, rst, en, clr, j;
    logic m0, m1, m2, q0, q1, q2;
    logic [7:0] c0, c1;
    logic [1:0] c2;
    int n_chk = 0;
    int n_fail = 0;

    seq_detector_param u0 (.clk(clk), .rst(rst), .en(en), .clr(clr), .j(j), .match(m0), .match_q(q0), .count(c0));
    seq_detector_param #(.OVERLAP(1'b0)) u1 (.clk(clk), .rst(rst), .en(en), .clr(clr), .j(j), .match(m1), .match_q(q1), .count(c1));
    seq_detector_param #(.OVERLAP(1'b0), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .en(en), .clr(clr), .j(j), .match(m2), .match_q(q2), .count(c2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // em = expected {u2,u1,u0} match for this bit; match_q must echo it after the edge
    task automatic step(input logic jv, input logic ev, input logic cv, input logic [2:0] em);
        @(negedge clk);
        j = jv;
        en = ev;
        clr = cv;
        #1 check("match", {29'd0, m2, m1, m0}, {29'd0, em});
        @(posedge clk);
        #1 check("match_q", {29'd0, q2, q1, q0}, {29'd0, em});
    endtask

    task automatic counts(input string tag, input int e0, input int e1, input int e2);
        check({tag, "_c0"}, 32'(c0), 32'(e0));
        check({tag, "_c1"}, 32'(c1), 32'(e1));
        check({tag, "_c2"}, 32'(c2), 32'(e2));
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; clr = 1'b0; j = 1'b0;
        #3 j = 1'b1; en = 1'b1;
        #1 check("rst_match", {29'd0, m2, m1, m0}, 32'd0);
        check("rst_match_q", {29'd0, q2, q1, q0}, 32'd0);
        counts("rst", 0, 0, 0);
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        // overlapping vs non-overlapping on 10010010
        step(1, 1, 0, 3'b000); step(0, 1, 0, 3'b000); step(0, 1, 0, 3'b000); step(1, 1, 0, 3'b000);
        step(0, 1, 0, 3'b111); step(0, 1, 0, 3'b000); step(1, 1, 0, 3'b000); step(0, 1, 0, 3'b001);
        counts("ovl", 2, 1, 1);
        step(1, 1, 1, 3'b000);
        counts("clr", 0, 0, 0);
        // enable gaps with j toggling, completing bit 0 held back by en
        step(1, 1, 0, 3'b000); step(0, 1, 0, 3'b000); step(0, 1, 0, 3'b000);
        step(1, 0, 0, 3'b000); step(0, 0, 0, 3'b000); step(1, 0, 0, 3'b000);
        step(1, 1, 0, 3'b000);
        step(0, 0, 0, 3'b000);
        counts("en_hold", 0, 0, 0);
        en = 1'b1; j = 1'b1;
        #1 check("comb_j1", {31'd0, m0}, 32'd0);
        j = 1'b0;
        #1 check("comb_j0", {31'd0, m0}, 32'd1);
        step(0, 1, 0, 3'b111);
        counts("gap", 1, 1, 1);
        // asynchronous reset mid-pattern
        step(1, 1, 0, 3'b000); step(0, 1, 0, 3'b000); step(0, 1, 0, 3'b000); step(1, 1, 0, 3'b000);
        #2 rst = 1'b0;
        #1 counts("async", 0, 0, 0);
        check("async_q", {29'd0, q2, q1, q0}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(0, 1, 0, 3'b000);
        counts("post_rst", 0, 0, 0);
        step(0, 1, 1, 3'b000);
        // counter saturation on 2-bit variant
        for (int r = 0; r < 5; r++) begin
            step(1, 1, 0, 3'b000); step(0, 1, 0, 3'b000); step(0, 1, 0, 3'b000); step(1, 1, 0, 3'b000);
            step(0, 1, 0, 3'b111);
            if (r == 2) counts("sat3", 3, 3, 3);
        end
        counts("sat", 5, 5, 3);
        // clr coinciding with a match
        step(1, 1, 0, 3'b000); step(0, 1, 0, 3'b000); step(0, 1, 0, 3'b000); step(1, 1, 0, 3'b000);
        step(0, 1, 1, 3'b000);
        counts("clr_win", 0, 0, 0);
        step(1, 1, 0, 3'b000); step(0, 1, 0, 3'b000); step(0, 1, 0, 3'b000); step(1, 1, 0, 3'b000);
        step(0, 1, 0, 3'b111);
        counts("fresh", 1, 1, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
